gpio_reader: RTL and testbench
==============================

GPIO_READER -- requirements
Module: gpio_reader

Interface
Parameters:
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive stable synchronized samples required to accept a new level (legal range 1..65535).
REQ-002 SHALL provide parameter CNT_W, default 16, meaning the width of the pulse-width counter and its output.

Ports:
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port dir, input, 1, pin direction; 1 = pin driven locally (reader frozen), 0 = pin is an input (reader active).
REQ-006 SHALL have port io_in, input, 1, raw asynchronous pin level (infrared sensor line).
REQ-007 SHALL have port clr, input, 1, one-cycle pulse that clears the sticky flags.
REQ-008 SHALL have port level, output, 1, debounced pin level.
REQ-009 SHALL have ports rise and fall, output, 1 each, single-cycle edge pulses.
REQ-010 SHALL have ports rise_flag and fall_flag, output, 1 each, sticky edge flags.
REQ-011 SHALL have port width, output, CNT_W, duration of the last completed high pulse, in clk cycles.
REQ-012 SHALL have port width_valid, output, 1, one-cycle pulse marking a new width value.

Function
REQ-013 io_in SHALL pass through a 2-FF synchronizer; the second stage (sync) is the only value the debouncer sees.
REQ-014 The debouncer SHALL be an FSM with states LOW, QUAL_HIGH, HIGH, QUAL_LOW and a qualification counter.
REQ-015 LOW: sync=1 -> QUAL_HIGH with counter=1; otherwise stay.
REQ-016 QUAL_HIGH: sync=0 -> LOW with counter=0; sync=1 and counter=DEBOUNCE_CYCLES -> HIGH with counter=0; otherwise counter+1.
REQ-017 HIGH and QUAL_LOW SHALL mirror REQ-015/REQ-016 with the polarities swapped.
REQ-018 With DEBOUNCE_CYCLES=1, an accepted transition SHALL occur on the edge after sync first differs.
REQ-019 level SHALL be 1 exactly when the state is HIGH or QUAL_LOW.
REQ-020 Latency SHALL be fixed: a clean io_in step reaches level DEBOUNCE_CYCLES+2 cycles after the step is sampled.
REQ-021 rise SHALL be high for exactly the first cycle level reads 1; fall SHALL be high for exactly the first cycle level reads 0; both are registered, and they are never high together.
REQ-022 rise_flag/fall_flag SHALL set on their edge pulse and clear on clr; a simultaneous set and clr SHALL leave the flag set.
REQ-023 The high-time counter SHALL load 1 on the rise cycle and increment each following cycle while level=1, saturating at 2^CNT_W-1 without wrap.
REQ-024 On the fall cycle, width SHALL take the counter value and width_valid SHALL pulse; width holds until the next fall.
REQ-025 While dir=1: the synchronizer keeps running; the FSM, counters, level and width SHALL hold; rise, fall and width_valid SHALL stay 0; flags hold.
REQ-026 On dir 1->0, qualification SHALL restart from the held state with the counter at 0.
REQ-027 A glitch shorter than DEBOUNCE_CYCLES+1 sync cycles SHALL produce no level change and no events.

Reset
REQ-028 rst SHALL force: synchronizer stages 0, state LOW, all counters 0, level 0, rise 0, fall 0, rise_flag 0, fall_flag 0, width 0, width_valid 0.
REQ-029 rst asserted mid-pulse or mid-qualification SHALL discard the partial measurement; no fall or width_valid SHALL be emitted for it.
REQ-030 rst SHALL take priority over dir and clr.

Structure
REQ-031 The FSM state encoding and the default parameter constants SHALL live in the shared package gpio_reader_pkg.
REQ-032 The synchronizer SHALL be the sub-module sync_2ff (1-bit, clk, rst); everything else SHALL stay in gpio_reader.

Verification (DEBOUNCE_CYCLES=4, CNT_W=16)
REQ-033 Reset, then io_in=1 held -> level=1 and rise pulse 6 cycles after the first sampling edge; rise_flag=1 afterwards.
REQ-034 io_in high for 3 cycles, then 0 -> level stays 0; no rise, no flags.
REQ-035 Clean high pulse of 100 cycles -> width=100 with a one-cycle width_valid on fall; a 70000-cycle pulse -> width=65535.
REQ-036 dir=1 while io_in toggles for 50 cycles -> no level change and no pulses; dir=0 with io_in stable at new level -> accepted after 5 sync cycles.
REQ-037 clr on the same cycle as fall -> fall_flag=1; clr one cycle later -> fall_flag=0.
REQ-038 rst at cycle 40 of a 100-cycle high pulse -> all outputs 0 next cycle; no width_valid follows.

Source files
------------

// File: rtl/gpio_reader_pkg.sv
// Shared debouncer state encoding and default constants for gpio_reader.
package gpio_reader_pkg;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CNT_W           = 16;
  localparam int QCNT_W              = 16;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    QUAL_HIGH = 2'd1,
    HIGH      = 2'd2,
    QUAL_LOW  = 2'd3
  } dbnc_state_e;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/gpio_reader.sv
// Debounced GPIO input reader: edge pulses, sticky flags and high-pulse width measurement.
module gpio_reader
  import gpio_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dir,
  input  logic             io_in,
  input  logic             clr,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic             rise_flag,
  output logic             fall_flag,
  output logic [CNT_W-1:0] width,
  output logic             width_valid
);
  localparam logic [QCNT_W-1:0] QMAX = QCNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  HMAX = '1;

  logic              sync;
  dbnc_state_e       state, nxt_state;
  logic [QCNT_W-1:0] qcnt, nxt_qcnt, qcur;
  logic [CNT_W-1:0]  hcnt;
  logic              dir_q, nxt_level;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (io_in),
    .q   (sync)
  );

  // Leaving a frozen period restarts qualification from zero.
  assign qcur = dir_q ? '0 : qcnt;

  always_comb begin
    nxt_state = state;
    nxt_qcnt  = '0;
    case (state)
      LOW: if (sync) begin
        nxt_state = QUAL_HIGH;
        nxt_qcnt  = QCNT_W'(1);
      end
      QUAL_HIGH: begin
        if (!sync)             nxt_state = LOW;
        else if (qcur == QMAX) nxt_state = HIGH;
        else                   nxt_qcnt  = qcur + QCNT_W'(1);
      end
      HIGH: if (!sync) begin
        nxt_state = QUAL_LOW;
        nxt_qcnt  = QCNT_W'(1);
      end
      QUAL_LOW: begin
        if (sync)              nxt_state = HIGH;
        else if (qcur == QMAX) nxt_state = LOW;
        else                   nxt_qcnt  = qcur + QCNT_W'(1);
      end
      default: nxt_state = LOW;
    endcase
  end

  assign nxt_level = (nxt_state == HIGH) || (nxt_state == QUAL_LOW);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOW;
      qcnt        <= '0;
      hcnt        <= '0;
      dir_q       <= 1'b0;
      level       <= 1'b0;
      rise        <= 1'b0;
      fall        <= 1'b0;
      rise_flag   <= 1'b0;
      fall_flag   <= 1'b0;
      width       <= '0;
      width_valid <= 1'b0;
    end else begin
      dir_q       <= dir;
      rise        <= 1'b0;
      fall        <= 1'b0;
      width_valid <= 1'b0;
      // Flags capture the pulse of the previous cycle, so a clr coincident with it loses.
      rise_flag   <= rise | (rise_flag & ~(clr & ~dir));
      fall_flag   <= fall | (fall_flag & ~(clr & ~dir));
      if (!dir) begin
        state <= nxt_state;
        qcnt  <= nxt_qcnt;
        level <= nxt_level;
        rise  <= ~level & nxt_level;
        fall  <= level & ~nxt_level;
        if (!level && nxt_level)
          hcnt <= CNT_W'(1);
        else if (level && nxt_level && hcnt != HMAX)
          hcnt <= hcnt + CNT_W'(1);
        if (level && !nxt_level) begin
          width       <= hcnt;
          width_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_gpio_reader.sv
// Self-checking bench for gpio_reader: vector table, corner sequences and a randomized model comparison.
module tb_gpio_reader;
  localparam int D = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, dir, io_in, clr;
  logic         level, rise, fall, rise_flag, fall_flag, width_valid;
  logic [W-1:0] width;

  int nchk = 0;
  int errors = 0;

  gpio_reader #(.DEBOUNCE_CYCLES(D), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .dir(dir), .io_in(io_in), .clr(clr),
    .level(level), .rise(rise), .fall(fall),
    .rise_flag(rise_flag), .fall_flag(fall_flag),
    .width(width), .width_valid(width_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         io, clr, dir;
    logic         lvl, rise, fall, rf, ff, wv;
    logic [W-1:0] width;
  } vec_t;

  vec_t tab[16];

  // Reference model: level flips once sync has disagreed with it for D+1 consecutive samples.
  logic         m_s1, m_s2, m_lvl, m_rise, m_fall, m_rf, m_ff, m_wv;
  int           m_run;
  int           m_hc;
  logic [W-1:0] m_w;

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_rise = 0; m_fall = 0;
    m_rf = 0; m_ff = 0; m_wv = 0; m_run = 0; m_hc = 0; m_w = '0;
  endtask

  task automatic model_step(input logic io, input logic c);
    logic nrf, nff, flip;
    nrf  = m_rise | (m_rf & ~c);
    nff  = m_fall | (m_ff & ~c);
    flip = 0;
    if (m_s2 != m_lvl) begin
      m_run++;
      if (m_run == D + 1) begin
        flip  = 1;
        m_run = 0;
      end
    end else m_run = 0;
    m_rise = flip & ~m_lvl;
    m_fall = flip & m_lvl;
    m_wv   = m_fall;
    if (m_fall) m_w = W'(m_hc);
    if (flip) m_lvl = ~m_lvl;
    if (m_rise) m_hc = 1;
    else if (m_lvl && m_hc < 65535) m_hc++;
    m_rf = nrf;
    m_ff = nff;
    m_s2 = m_s1;
    m_s1 = io;
  endtask

  task automatic do_reset();
    rst = 1; io_in = 0; clr = 0; dir = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    int n;

    // Step response, clr of rise_flag, and the matching fall with an 8-cycle width.
    for (int i = 0; i < 16; i++) begin
      tab[i] = '{io: 1, clr: 0, dir: 0, lvl: 0, rise: 0, fall: 0, rf: 0, ff: 0, wv: 0, width: 0};
      if (i >= 8) tab[i].io = 0;
      if (i >= 6 && i <= 13) tab[i].lvl = 1;
      if (i == 7) tab[i].rf = 1;
    end
    tab[6].rise = 1;
    tab[8].clr  = 1;
    tab[14].fall = 1; tab[14].wv = 1;
    tab[14].width = 8; tab[15].width = 8; tab[15].ff = 1;

    do_reset();
    chk("reset_level", level, 0);
    chk("reset_pulses", {rise, fall, width_valid}, 0);
    chk("reset_flags", {rise_flag, fall_flag}, 0);
    chk("reset_width", width, 0);

    for (int i = 0; i < 16; i++) begin
      io_in = tab[i].io; clr = tab[i].clr; dir = tab[i].dir;
      tick();
      chk($sformatf("vec%0d_level", i), level, tab[i].lvl);
      chk($sformatf("vec%0d_edges", i), {rise, fall}, {tab[i].rise, tab[i].fall});
      chk($sformatf("vec%0d_flags", i), {rise_flag, fall_flag}, {tab[i].rf, tab[i].ff});
      chk($sformatf("vec%0d_wv", i), width_valid, tab[i].wv);
      if (tab[i].wv) chk($sformatf("vec%0d_width", i), width, tab[i].width);
    end
    clr = 0;

    // Glitch of 3 cycles must be filtered.
    do_reset();
    io_in = 1;
    repeat (3) tick();
    io_in = 0;
    found = 0;
    repeat (14) begin
      tick();
      if (level || rise || fall || rise_flag || fall_flag) found = 1;
    end
    chk("glitch_filtered", found, 0);

    // 100-cycle pulse.
    do_reset();
    io_in = 1;
    repeat (100) tick();
    io_in = 0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (width_valid) found = 1;
    end
    chk("w100_seen", found, 1);
    chk("w100_width", width, 100);
    tick();
    chk("w100_wv_one_cycle", width_valid, 0);

    // Saturation on a 70000-cycle pulse.
    io_in = 1;
    repeat (70000) tick();
    io_in = 0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (width_valid) found = 1;
    end
    chk("wsat_seen", found, 1);
    chk("wsat_width", width, 65535);

    // Frozen reader while the pin toggles, then release with the pin high.
    do_reset();
    dir = 1;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      io_in = k[0];
      tick();
      if (level || rise || fall || width_valid) found = 1;
    end
    chk("dir_frozen", found, 0);
    io_in = 1;
    repeat (3) tick();
    dir = 0;
    repeat (4) tick();
    chk("dir_release_4", level, 0);
    tick();
    chk("dir_release_5", {level, rise}, 2'b11);

    // clr coincident with fall keeps the flag; clr one cycle later clears it.
    io_in = 0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (fall) found = 1;
    end
    chk("fall1_seen", found, 1);
    clr = 1;
    tick();
    clr = 0;
    chk("clr_same_cycle", fall_flag, 1);
    io_in = 1;
    repeat (10) tick();
    io_in = 0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (fall) found = 1;
    end
    chk("fall2_seen", found, 1);
    tick();
    chk("flag_before_clr", fall_flag, 1);
    clr = 1;
    tick();
    clr = 0;
    chk("clr_next_cycle", fall_flag, 0);

    // Reset partway through a pulse discards the measurement.
    do_reset();
    io_in = 1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (rise) found = 1;
    end
    chk("rst_mid_rise_seen", found, 1);
    repeat (39) tick();
    rst = 1; io_in = 0;
    tick();
    chk("rst_mid_outputs", {level, rise, fall, rise_flag, fall_flag, width_valid}, 0);
    chk("rst_mid_width", width, 0);
    rst = 0;
    found = 0;
    repeat (100) begin
      tick();
      if (width_valid || fall) found = 1;
    end
    chk("rst_mid_no_event", found, 0);

    // Randomized runs against the reference model.
    do_reset();
    model_reset();
    n = 0;
    while (n < 1500) begin
      logic lvl_r;
      int   run;
      lvl_r = 1'($urandom_range(0, 1));
      run   = $urandom_range(1, 12);
      for (int k = 0; k < run; k++) begin
        io_in = lvl_r;
        clr   = ($urandom_range(0, 15) == 0);
        model_step(io_in, clr);
        tick();
        chk("rand_level", level, m_lvl);
        chk("rand_edges", {rise, fall, width_valid}, {m_rise, m_fall, m_wv});
        chk("rand_flags", {rise_flag, fall_flag}, {m_rf, m_ff});
        chk("rand_width", width, m_w);
        n++;
      end
    end
    clr = 0;

    $display("Result: errors=%0d of %0d checks", errors, nchk);
    $finish;
  end
endmodule
